// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_DEPTH_WORDS = 512;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: each lane takes the new word where its enable is set, else the old word.
module be_merge (
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_word_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = new_word_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer (IDLE -> ACCESS -> RESP) with byte-enable RMW on a word-write memory.
// Optional: define DMEM_ARB_RANGE_CHK_EN to reject addresses beyond the memory with rsp_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic        m0_req_we,
    input  logic [3:0]  m0_req_be,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic        m1_req_we,
    input  logic [3:0]  m1_req_be,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_w_en,
    output logic        mem_read_en,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    arb_state_t  state_q, state_d;
    mem_req_t    req_q, req_d;
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic        m0_rsp_valid_q, m0_rsp_valid_d, m1_rsp_valid_q, m1_rsp_valid_d;
    logic [31:0] m0_rsp_rdata_q, m0_rsp_rdata_d, m1_rsp_rdata_q, m1_rsp_rdata_d;
    logic        m0_rsp_err_q, m0_rsp_err_d, m1_rsp_err_q, m1_rsp_err_d;

    logic        grant;
    logic        in_idle;
    logic        in_access;
    logic        out_of_range;
    logic [31:0] merged_word;
    logic [31:0] rsp_word;
    logic        unused_addr;

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign out_of_range = |req_q.addr[31:IDX_W+2];
    assign unused_addr  = ^req_q.addr[1:0];
`else
    assign out_of_range = 1'b0;
    assign unused_addr  = ^{req_q.addr[31:IDX_W+2], req_q.addr[1:0]};
`endif

    // On a tie the requester that did not win last time gets the grant.
    assign grant        = m1_req_valid && (!m0_req_valid || !last_grant_q);
    assign in_idle      = (state_q == IDLE) && !rst;
    assign in_access    = (state_q == ACCESS);
    assign m0_req_ready = in_idle && m0_req_valid && !grant;
    assign m1_req_ready = in_idle && m1_req_valid && grant;

    be_merge u_be_merge (
        .old_word_i (mem_data_out),
        .new_word_i (req_q.wdata),
        .be_i       (req_q.be),
        .merged_o   (merged_word)
    );

    assign mem_addr    = in_access ? {{(32 - IDX_W){1'b0}}, req_q.addr[IDX_W+1:2]} : 32'h0;
    assign mem_data_in = in_access ? merged_word : 32'h0;
    assign mem_read_en = in_access && !out_of_range;
    // Gating with rst keeps a write from landing in the cycle reset arrives.
    assign mem_w_en    = in_access && req_q.we && (|req_q.be) && !out_of_range && !rst;
    assign rsp_word    = (req_q.we || out_of_range) ? 32'h0 : mem_data_out;

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        gnt_d          = gnt_q;
        last_grant_d   = last_grant_q;
        m0_rsp_valid_d = 1'b0;
        m1_rsp_valid_d = 1'b0;
        m0_rsp_rdata_d = m0_rsp_rdata_q;
        m1_rsp_rdata_d = m1_rsp_rdata_q;
        m0_rsp_err_d   = m0_rsp_err_q;
        m1_rsp_err_d   = m1_rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req_ready || m1_req_ready) begin
                    req_d.addr   = grant ? m1_req_addr  : m0_req_addr;
                    req_d.we     = grant ? m1_req_we    : m0_req_we;
                    req_d.be     = grant ? m1_req_be    : m0_req_be;
                    req_d.wdata  = grant ? m1_req_wdata : m0_req_wdata;
                    gnt_d        = grant;
                    last_grant_d = grant;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (gnt_q) begin
                    m1_rsp_valid_d = 1'b1;
                    m1_rsp_rdata_d = rsp_word;
                    m1_rsp_err_d   = out_of_range;
                end else begin
                    m0_rsp_valid_d = 1'b1;
                    m0_rsp_rdata_d = rsp_word;
                    m0_rsp_err_d   = out_of_range;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            req_q          <= '0;
            gnt_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            m0_rsp_valid_q <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            m0_rsp_rdata_q <= 32'h0;
            m1_rsp_rdata_q <= 32'h0;
            m0_rsp_err_q   <= 1'b0;
            m1_rsp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            gnt_q          <= gnt_d;
            last_grant_q   <= last_grant_d;
            m0_rsp_valid_q <= m0_rsp_valid_d;
            m1_rsp_valid_q <= m1_rsp_valid_d;
            m0_rsp_rdata_q <= m0_rsp_rdata_d;
            m1_rsp_rdata_q <= m1_rsp_rdata_d;
            m0_rsp_err_q   <= m0_rsp_err_d;
            m1_rsp_err_q   <= m1_rsp_err_d;
        end
    end

    assign m0_rsp_valid = m0_rsp_valid_q;
    assign m1_rsp_valid = m1_rsp_valid_q;
    assign m0_rsp_rdata = m0_rsp_rdata_q;
    assign m1_rsp_rdata = m1_rsp_rdata_q;
    assign m0_rsp_err   = m0_rsp_err_q;
    assign m1_rsp_err   = m1_rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 512-word behavioural memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [3:0]  m0_req_be;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_be;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_w_en, mem_read_en;

    logic [31:0] mem [0:511];
    logic        bd_en = 1'b0;
    logic [8:0]  bd_idx;
    logic [31:0] bd_data;
    int          wen_count = 0;
    int          checks = 0;
    int          errors = 0;
    int          wen_snap;
    logic        unused_tb;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_addr  (m0_req_addr),
        .m0_req_we    (m0_req_we),
        .m0_req_be    (m0_req_be),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_addr  (m1_req_addr),
        .m1_req_we    (m1_req_we),
        .m1_req_be    (m1_req_be),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_w_en     (mem_w_en),
        .mem_read_en  (mem_read_en),
        .mem_data_out (mem_data_out)
    );

    assign mem_data_out = mem[mem_addr[8:0]];
    assign unused_tb    = ^mem_addr[31:9];

    always @(posedge clk) begin
        if (mem_w_en) begin
            mem[mem_addr[8:0]] <= mem_data_in;
            wen_count <= wen_count + 1;
        end else if (bd_en) begin
            mem[bd_idx] <= bd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [8:0] idx, input logic [31:0] data);
        bd_idx  = idx;
        bd_data = data;
        bd_en   = 1'b1;
        @(negedge clk);
        bd_en   = 1'b0;
    endtask

    // Called at a negedge in IDLE with requests already driven; returns at the next IDLE negedge.
    task automatic txn(input logic g, input logic exp_wen, input logic exp_rd,
                       input logic [31:0] exp_idx, input logic [31:0] exp_din,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic keep);
        #1;
        chk1("ready_m0", m0_req_ready, !g);
        chk1("ready_m1", m1_req_ready, g);
        @(negedge clk);
        if (!keep) begin
            m0_req_valid = 1'b0;
            m1_req_valid = 1'b0;
        end
        #1;
        chk("access_mem_addr", mem_addr, exp_idx);
        chk1("access_mem_read_en", mem_read_en, exp_rd);
        chk1("access_mem_w_en", mem_w_en, exp_wen);
        if (exp_wen) chk("access_mem_data_in", mem_data_in, exp_din);
        @(negedge clk);
        chk1("rsp_valid_granted", g ? m1_rsp_valid : m0_rsp_valid, 1'b1);
        chk1("rsp_valid_other", g ? m0_rsp_valid : m1_rsp_valid, 1'b0);
        chk("rsp_rdata", g ? m1_rsp_rdata : m0_rsp_rdata, exp_rdata);
        chk1("rsp_err", g ? m1_rsp_err : m0_rsp_err, exp_err);
        @(negedge clk);
        chk1("rsp_valid_m0_after", m0_rsp_valid, 1'b0);
        chk1("rsp_valid_m1_after", m1_rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_req_valid = 1'b0; m0_req_addr = 32'h0; m0_req_we = 1'b0; m0_req_be = 4'h0;
        m0_req_wdata = 32'h0;
        m1_req_valid = 1'b0; m1_req_addr = 32'h0; m1_req_we = 1'b0; m1_req_be = 4'h0;
        m1_req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_ready_m0", m0_req_ready, 1'b0);
        chk1("rst_ready_m1", m1_req_ready, 1'b0);
        chk1("rst_rsp_valid_m0", m0_rsp_valid, 1'b0);
        chk1("rst_rsp_valid_m1", m1_rsp_valid, 1'b0);
        chk("rst_rdata_m0", m0_rsp_rdata, 32'h0);
        chk("rst_rdata_m1", m1_rsp_rdata, 32'h0);
        chk1("rst_err_m0", m0_rsp_err, 1'b0);
        chk1("rst_err_m1", m1_rsp_err, 1'b0);
        chk1("rst_mem_w_en", mem_w_en, 1'b0);
        chk1("rst_mem_read_en", mem_read_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Full-word write then read back through m0.
        m0_req_valid = 1'b1; m0_req_addr = 32'h10; m0_req_we = 1'b1; m0_req_be = 4'hF;
        m0_req_wdata = 32'hDEADBEEF;
        txn(1'b0, 1'b1, 1'b1, 32'd4, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        chk("mem4_after_write", mem[4], 32'hDEADBEEF);
        chk("wen_pulses_write", wen_count, 1);
        m0_req_valid = 1'b1; m0_req_we = 1'b0;
        txn(1'b0, 1'b0, 1'b1, 32'd4, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Partial-lane write from m1.
        preload(9'd4, 32'h11223344);
        m1_req_valid = 1'b1; m1_req_addr = 32'h10; m1_req_we = 1'b1; m1_req_be = 4'b0010;
        m1_req_wdata = 32'h0000AA00;
        txn(1'b1, 1'b1, 1'b1, 32'd4, 32'h1122AA44, 32'h0, 1'b0, 1'b0);
        chk("mem4_after_merge", mem[4], 32'h1122AA44);

        // Back-to-back ties after reset alternate m0, m1, m0, m1.
        preload(9'd1, 32'hA0A0A0A1);
        preload(9'd2, 32'hB0B0B0B2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_req_addr = 32'h4; m0_req_we = 1'b0; m0_req_be = 4'hF;
        m1_req_valid = 1'b1; m1_req_addr = 32'h8; m1_req_we = 1'b0; m1_req_be = 4'hF;
        txn(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 32'hA0A0A0A1, 1'b0, 1'b1);
        chk("tie_m1_rdata_held", m1_rsp_rdata, 32'h0);
        txn(1'b1, 1'b0, 1'b1, 32'd2, 32'h0, 32'hB0B0B0B2, 1'b0, 1'b1);
        chk("tie_m0_rdata_held", m0_rsp_rdata, 32'hA0A0A0A1);
        txn(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 32'hA0A0A0A1, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 1'b1, 32'd2, 32'h0, 32'hB0B0B0B2, 1'b0, 1'b0);

        // Write with no byte enables leaves memory untouched.
        preload(9'd8, 32'h55);
        wen_snap = wen_count;
        m0_req_valid = 1'b1; m0_req_addr = 32'h20; m0_req_we = 1'b1; m0_req_be = 4'h0;
        m0_req_wdata = 32'hFFFFFFFF;
        txn(1'b0, 1'b0, 1'b1, 32'd8, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mem8_be0_unchanged", mem[8], 32'h55);
        chk("wen_pulses_be0", wen_count, wen_snap);

        // Reset during the ACCESS cycle of a write aborts it.
        preload(9'd12, 32'h0);
        wen_snap = wen_count;
        m0_req_valid = 1'b1; m0_req_addr = 32'h30; m0_req_we = 1'b1; m0_req_be = 4'hF;
        m0_req_wdata = 32'hCAFEF00D;
        #1;
        chk1("abort_ready_m0", m0_req_ready, 1'b1);
        @(negedge clk);
        m0_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk1("abort_mem_w_en", mem_w_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("abort_rsp_valid_m0", m0_rsp_valid, 1'b0);
        chk1("abort_rsp_valid_m1", m1_rsp_valid, 1'b0);
        @(negedge clk);
        chk1("abort_rsp_valid_m0_late", m0_rsp_valid, 1'b0);
        chk("abort_mem12", mem[12], 32'h0);
        chk("abort_wen_pulses", wen_count, wen_snap);
        m0_req_valid = 1'b1; m0_req_addr = 32'h4; m0_req_we = 1'b0;
        m1_req_valid = 1'b1; m1_req_addr = 32'h8; m1_req_we = 1'b0;
        txn(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 32'hA0A0A0A1, 1'b0, 1'b0);

        // Address beyond the memory: flagged with the range check, wraps to word 0 without it.
        preload(9'd0, 32'h0BADC0DE);
        m1_req_valid = 1'b1; m1_req_addr = 32'h800; m1_req_we = 1'b0; m1_req_be = 4'hF;
`ifdef DMEM_ARB_RANGE_CHK_EN
        txn(1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1, 1'b0);
`else
        txn(1'b1, 1'b0, 1'b1, 32'd0, 32'h0, 32'h0BADC0DE, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
